// File: rtl/dcache_refill_ctrl.sv
// Dcache miss engine: optional dirty-victim writeback over AXI W, then an
// 8-beat INCR line refill written word-by-word into the per-word data RAM banks.
module dcache_refill_ctrl #(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = 4'd1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         miss_req,
   input  logic [31:0]  miss_addr,
   input  logic         miss_dirty,
   input  logic [19:0]  victim_tag,
   output logic         busy,
   output logic         refill_done,
   output logic [7:0]   ram_en,
   output logic [3:0]   ram_wen,
   output logic [31:0]  ram_addr,
   output logic [31:0]  ram_wdata,
   input  logic [255:0] ram_rdata,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [31:0]  rdata,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic         bvalid,
   output logic         bready
);

   localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WB_RD, S_WB_CAP, S_WB_AW, S_WB_W, S_WB_B, S_RF_AR, S_RF_R, S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [26:0]    line_base;
   logic [19:0]    tag;
   logic [255:0]   line_buf;
   logic [2:0]     cnt;

   // Byte offset within the line is irrelevant: every transfer is a whole line.
   logic unused_offset;
   assign unused_offset = ^miss_addr[4:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_base <= '0;
         tag       <= '0;
         line_buf  <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE:   if (miss_req) begin
                         line_base <= miss_addr[31:5];
                         tag       <= victim_tag;
                      end
            S_WB_CAP: line_buf <= ram_rdata;
            S_WB_AW:  if (awready) cnt <= '0;
            S_WB_W:   if (wready)  cnt <= cnt + 3'd1;
            S_RF_AR:  if (arready) cnt <= '0;
            S_RF_R:   if (rvalid)  cnt <= cnt + 3'd1;
            default:  ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != S_IDLE);
      refill_done = 1'b0;
      ram_en      = '0;
      ram_wen     = '0;
      ram_addr    = '0;
      ram_wdata   = '0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      awvalid     = 1'b0;
      wvalid      = 1'b0;
      wlast       = 1'b0;
      bready      = 1'b0;
      case (state)
         S_IDLE:   if (miss_req) state_nxt = miss_dirty ? S_WB_RD : S_RF_AR;
         S_WB_RD: begin
            ram_en    = 8'hff;
            ram_addr  = {line_base, 5'b0};
            state_nxt = S_WB_CAP;
         end
         // RAM read data is valid the cycle after the enable.
         S_WB_CAP: state_nxt = S_WB_AW;
         S_WB_AW: begin
            awvalid = 1'b1;
            if (awready) state_nxt = S_WB_W;
         end
         S_WB_W: begin
            wvalid = 1'b1;
            wlast  = (cnt == LAST_WORD);
            if (wready && wlast) state_nxt = S_WB_B;
         end
         S_WB_B: begin
            bready = 1'b1;
            if (bvalid) state_nxt = S_RF_AR;
         end
         S_RF_AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = S_RF_R;
         end
         S_RF_R: begin
            rready = 1'b1;
            if (rvalid) begin
               ram_en    = 8'b1 << cnt;
               ram_wen   = 4'hf;
               ram_wdata = rdata;
               ram_addr  = {line_base, cnt, 2'b00};
               // An early rlast truncates the line; the 8th beat ends it regardless.
               if (rlast || cnt == LAST_WORD) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            refill_done = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign wdata   = line_buf[{cnt, 5'b0} +: 32];
   assign wstrb   = 4'hf;
   assign arid    = AXI_ID;
   assign araddr  = {line_base, 5'b0};
   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = 3'd2;
   assign arburst = 2'b01;
   assign awid    = AXI_ID;
   assign awaddr  = {tag, line_base[6:0], 5'b0};
   assign awlen   = 8'(LINE_WORDS - 1);
   assign awsize  = 3'd2;
   assign awburst = 2'b01;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: clean, dirty, backpressured, truncated,
// reset-interrupted and back-to-back misses against a simple banked RAM model.
module tb_dcache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         miss_req, miss_dirty;
   logic [31:0]  miss_addr;
   logic [19:0]  victim_tag;
   logic         busy, refill_done;
   logic [7:0]   ram_en;
   logic [3:0]   ram_wen;
   logic [31:0]  ram_addr, ram_wdata;
   logic [255:0] ram_rdata;
   logic [3:0]   arid, awid;
   logic [31:0]  araddr, awaddr;
   logic [7:0]   arlen, awlen;
   logic [2:0]   arsize, awsize;
   logic [1:0]   arburst, awburst;
   logic         arvalid, arready, rlast, rvalid, rready;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [31:0]  rdata, wdata;
   logic [3:0]   wstrb;

   dcache_refill_ctrl dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .miss_dirty(miss_dirty), .victim_tag(victim_tag), .busy(busy),
      .refill_done(refill_done), .ram_en(ram_en), .ram_wen(ram_wen),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid),
      .bready(bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Banked data RAM: sampled just before the rising edge, when inputs have settled.
   logic [31:0] mem [8][128];
   int          bank_wr [8];
   int          snap [8];
   always @(negedge clk) begin
      #4;
      if (!rst)
         for (int n = 0; n < 8; n++)
            if (ram_en[n] && ram_wen == 4'hf) begin
               mem[n][ram_addr[11:5]] <= ram_wdata;
               bank_wr[n]             <= bank_wr[n] + 1;
            end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] w0);
      logic [255:0] l;
      for (int n = 0; n < 8; n++) l[n*32 +: 32] = w0 + 32'(n);
      return l;
   endfunction

   task automatic take_snap();
      for (int n = 0; n < 8; n++) snap[n] = bank_wr[n];
   endtask

   task automatic chk_line(input logic [6:0] idx, input logic [31:0] w0, input logic [7:0] mask);
      for (int n = 0; n < 8; n++) begin
         if (mask[n]) begin
            chk("bank_data", mem[n][idx], w0 + 32'(n));
            chk("bank_writes", 32'(bank_wr[n] - snap[n]), 32'd1);
         end else begin
            chk("bank_untouched", 32'(bank_wr[n] - snap[n]), 32'd0);
         end
      end
   endtask

   task automatic accept(input logic [31:0] addr, input logic dirty, input logic [19:0] vt);
      @(negedge clk);
      miss_req = 1'b1; miss_addr = addr; miss_dirty = dirty; victim_tag = vt;
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   // Entered with the DUT about to sit in WB_RD.
   task automatic do_wb_head(input logic [31:0] aw_exp, input logic [6:0] idx,
                             input logic [255:0] line, input int aw_wait);
      @(negedge clk);
      miss_req = 1'b0; ram_rdata = ~line; #1;
      chk("wbrd_en", 32'(ram_en), 32'hff);
      chk("wbrd_wen", 32'(ram_wen), 32'd0);
      chk("wbrd_idx", 32'(ram_addr[11:5]), 32'(idx));
      chk("wbrd_busy", 32'(busy), 32'd1);
      @(negedge clk);
      ram_rdata = line; #1;
      chk("wbcap_en", 32'(ram_en), 32'd0);
      chk("wbcap_awvalid", 32'(awvalid), 32'd0);
      for (int s = 0; s < aw_wait; s++) begin
         @(negedge clk);
         ram_rdata = ~line; awready = 1'b0; #1;
         chk("aw_hold", 32'(awvalid), 32'd1);
         chk("aw_addr_hold", awaddr, aw_exp);
      end
      @(negedge clk);
      ram_rdata = ~line; awready = 1'b1; #1;
      chk("awvalid", 32'(awvalid), 32'd1);
      chk("awaddr", awaddr, aw_exp);
      chk("awlen", 32'(awlen), 32'd7);
      chk("awsize", 32'(awsize), 32'd2);
      chk("awburst", 32'(awburst), 32'd1);
      chk("awid", 32'(awid), 32'd1);
      chk("aw_wvalid", 32'(wvalid), 32'd0);
   endtask

   task automatic do_wb(input logic [31:0] w0, input bit toggle);
      for (int i = 0; i < 8; i++) begin
         if (toggle && i > 0) begin
            @(negedge clk);
            awready = 1'b0; wready = 1'b0; #1;
            chk("w_stall_valid", 32'(wvalid), 32'd1);
            chk("w_stall_data", wdata, w0 + 32'(i));
            chk("w_stall_last", 32'(wlast), 32'(i == 7));
         end
         @(negedge clk);
         awready = 1'b0; wready = 1'b1; #1;
         chk("wvalid", 32'(wvalid), 32'd1);
         chk("wdata", wdata, w0 + 32'(i));
         chk("wlast", 32'(wlast), 32'(i == 7));
         chk("wstrb", 32'(wstrb), 32'hf);
         chk("w_awvalid", 32'(awvalid), 32'd0);
      end
      @(negedge clk);
      wready = 1'b0; #1;
      chk("b_wvalid", 32'(wvalid), 32'd0);
      chk("bready", 32'(bready), 32'd1);
      chk("b_no_ar", 32'(arvalid), 32'd0);
      @(negedge clk);
      bvalid = 1'b1; #1;
      chk("bready_hold", 32'(bready), 32'd1);
      chk("b_no_ar2", 32'(arvalid), 32'd0);
   endtask

   // Entered with the DUT about to sit in RF_AR; gaps[i] inserts an idle cycle before beat i.
   task automatic do_refill(input logic [31:0] base, input logic [31:0] w0, input int last_idx,
                            input logic [7:0] gaps, input int ar_wait, input logic hold_req,
                            output int done_cyc);
      for (int s = 0; s < ar_wait; s++) begin
         @(negedge clk);
         miss_req = hold_req; bvalid = 1'b0; arready = 1'b0; #1;
         chk("ar_hold", 32'(arvalid), 32'd1);
         chk("ar_addr_hold", araddr, base);
      end
      @(negedge clk);
      miss_req = hold_req; bvalid = 1'b0; arready = 1'b1; #1;
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", araddr, base);
      chk("arlen", 32'(arlen), 32'd7);
      chk("arsize", 32'(arsize), 32'd2);
      chk("arburst", 32'(arburst), 32'd1);
      chk("arid", 32'(arid), 32'd1);
      chk("ar_rready", 32'(rready), 32'd0);
      for (int i = 0; i <= last_idx; i++) begin
         if (gaps[i]) begin
            @(negedge clk);
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; #1;
            chk("r_gap_en", 32'(ram_en), 32'd0);
            chk("r_gap_rready", 32'(rready), 32'd1);
         end
         @(negedge clk);
         arready = 1'b0; rvalid = 1'b1; rdata = w0 + 32'(i); rlast = (i == last_idx); #1;
         chk("r_rready", 32'(rready), 32'd1);
         chk("r_ram_en", 32'(ram_en), 32'(8'b1 << i));
         chk("r_ram_wen", 32'(ram_wen), 32'hf);
         chk("r_ram_addr", ram_addr, base + 32'(4 * i));
         chk("r_ram_wdata", ram_wdata, w0 + 32'(i));
      end
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; #1;
      chk("refill_done", 32'(refill_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      done_cyc = cyc;
      @(negedge clk);
      #1;
      chk("done_pulse_end", 32'(refill_done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int acc, dc;
      miss_req = 0; miss_addr = 0; miss_dirty = 0; victim_tag = 0; ram_rdata = 0;
      arready = 0; rdata = 0; rlast = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(refill_done), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_wen", 32'(ram_wen), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_wlast", 32'(wlast), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      rst = 1'b0;

      // Clean miss, zero-wait slave.
      take_snap();
      accept(32'h0000_1234, 1'b0, 20'h0);
      acc = cyc;
      do_refill(32'h0000_1220, 32'hA0, 7, 8'h00, 0, 1'b0, dc);
      chk("clean_latency", 32'(dc - acc), 32'd10);
      chk_line(7'h11, 32'hA0, 8'hff);

      // Dirty miss: writeback then refill of the same index.
      take_snap();
      accept(32'h0000_1234, 1'b1, 20'h12345);
      do_wb_head(32'h1234_5220, 7'h11, mk_line(32'hD0), 0);
      do_wb(32'hD0, 1'b0);
      do_refill(32'h0000_1220, 32'hB0, 7, 8'h00, 0, 1'b0, dc);
      chk_line(7'h11, 32'hB0, 8'hff);

      // Backpressure on AW, W, AR and R.
      take_snap();
      accept(32'h8000_0ABC, 1'b1, 20'hFEDCB);
      do_wb_head(32'hFEDC_BAA0, 7'h55, mk_line(32'hE0), 2);
      do_wb(32'hE0, 1'b1);
      do_refill(32'h8000_0AA0, 32'hC0, 7, 8'b1010_0110, 2, 1'b0, dc);
      chk_line(7'h55, 32'hC0, 8'hff);

      // Early rlast on the 4th beat.
      take_snap();
      accept(32'h0000_0040, 1'b0, 20'h0);
      do_refill(32'h0000_0040, 32'h90, 3, 8'h00, 0, 1'b0, dc);
      chk_line(7'h02, 32'h90, 8'h0f);

      // Reset during the 4th refill beat.
      take_snap();
      accept(32'h0000_3FE0, 1'b0, 20'h0);
      @(negedge clk);
      miss_req = 1'b0; arready = 1'b1; #1;
      chk("rstt_arvalid", 32'(arvalid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         arready = 1'b0; rvalid = 1'b1; rdata = 32'h60 + 32'(i); rlast = 1'b0; #1;
         chk("rstt_ram_en", 32'(ram_en), 32'(8'b1 << i));
      end
      rst = 1'b1; #1;
      chk("rstt_ram_en0", 32'(ram_en), 32'd0);
      chk("rstt_ram_wen0", 32'(ram_wen), 32'd0);
      chk("rstt_rready0", 32'(rready), 32'd0);
      chk("rstt_busy0", 32'(busy), 32'd0);
      chk("rstt_araddr0", araddr, 32'd0);
      chk("rstt_ram_addr0", ram_addr, 32'd0);
      chk("rstt_done0", 32'(refill_done), 32'd0);
      @(negedge clk);
      rvalid = 1'b0; rst = 1'b0; #1;
      chk("rstt_idle", 32'(busy), 32'd0);
      chk_line(7'h7f, 32'h60, 8'h07);
      take_snap();
      accept(32'h0000_3FE0, 1'b0, 20'h0);
      do_refill(32'h0000_3FE0, 32'h50, 7, 8'h00, 0, 1'b0, dc);
      chk_line(7'h7f, 32'h50, 8'hff);

      // miss_req held high: address changes while busy are ignored, next miss taken right after DONE.
      take_snap();
      accept(32'h0000_0100, 1'b0, 20'h0);
      @(posedge clk);
      #1 miss_addr = 32'h0000_0200;
      do_refill(32'h0000_0100, 32'h70, 7, 8'h00, 0, 1'b1, dc);
      chk_line(7'h08, 32'h70, 8'hff);
      take_snap();
      do_refill(32'h0000_0200, 32'h78, 7, 8'h00, 0, 1'b0, dc);
      chk_line(7'h10, 32'h78, 8'hff);
      @(negedge clk);
      #1;
      chk("final_idle", 32'(busy), 32'd0);
      chk("final_arvalid", 32'(arvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
Miss-handling engine between the dcache pipeline and the AXI master port. On a miss it optionally writes back the dirty victim line, then burst-reads the missing 32-byte line (8 words) and writes each word into the per-word data RAM banks. The data RAM banks are indexed by addr[11:5], with byte write enables. Handles one outstanding miss.

Parameters:
LINE_WORDS, 8, words per line; fixed to match the 32-byte line and addr[4:2] bank select.
AXI_ID, 4'd1, constant ARID/AWID driven on bursts.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
miss_req  input  1  pulse or level; sampled only in IDLE
miss_addr  input  32  miss address; line base = {miss_addr[31:5],5'b0}
miss_dirty  input  1  victim line dirty, writeback required
victim_tag  input  20  victim tag, address bits [31:12]
busy  output  1  high from miss accept through DONE
refill_done  output  1  one-cycle pulse; line is valid in RAM
ram_en  output  8  per-bank enable, bank n = word n of line
ram_wen  output  4  byte write enable (4'hf on refill, 0 on read)
ram_addr  output  32  RAM address; banks use [11:5]
ram_wdata  output  32  refill word
ram_rdata  input  256  concatenated bank outputs, word n at [32n+31:32n]; 1-cycle read latency
arid  output  4  AXI_ID
araddr  output  32  line base address
arlen  output  8  8'd7
arsize  output  3  3'd2
arburst  output  2  2'b01 INCR
arvalid  output  1  read address valid
arready  input  1
rdata  input  32
rlast  input  1
rvalid  input  1
rready  output  1
awid  output  4  AXI_ID
awaddr  output  32  {victim_tag, miss_addr[11:5], 5'b0}
awlen  output  8  8'd7
awsize  output  3  3'd2
awburst  output  2  2'b01
awvalid  output  1
awready  input  1
wdata  output  32
wstrb  output  4  4'hf
wlast  output  1
wvalid  output  1
wready  input  1
bvalid  input  1
bready  output  1

Behaviour:
- Reset: state IDLE. busy, refill_done, ram_en, ram_wen, arvalid, rready, awvalid, wvalid, wlast, bready all 0. Address and data regs are 0. Word counter is 0.
- IDLE: when miss_req=1, latch miss_addr, miss_dirty and victim_tag, and set busy. Next state is WB_RD if dirty, else RF_AR.
- WB_RD: assert ram_en=8'hff, ram_wen=0, ram_addr=latched index for 1 cycle. Next cycle, capture ram_rdata into a 256-bit line buffer, then go to WB_AW.
- WB_AW: awvalid held until awready. Then go to WB_W, counter=0.
- WB_W: wvalid=1; wdata=buffer word[counter]; wlast when counter==7. Each wvalid&wready advances counter. After the beat with wlast, go to WB_B.
- WB_B: bready=1. On bvalid, go to RF_AR. BRESP is ignored.
- RF_AR: arvalid held until arready. Address and attributes are stable while valid. Then go to RF_R, counter=0.
- RF_R: rready=1. Each rvalid beat writes rdata into the data RAM in the same cycle:
  - ram_en = one-hot(counter), ram_wen=4'hf, ram_wdata=rdata, ram_addr={line base[31:5], counter, 2'b00}.
  - Counter increments and wraps 7->0.
  - On a beat with rlast, or the 8th beat (whichever first), go to DONE. An early rlast truncates the refill and remaining words are not written.
- DONE: refill_done=1 for exactly 1 cycle, busy=1. Next cycle go to IDLE with busy=0.
- A new miss_req is accepted only in IDLE; it is ignored while busy.
- AXI valid signals never drop before the handshake completes. Ready/valid on the same cycle completes the transfer.
- Latency, clean miss with zero-wait slave: AR 1 cycle + 8 R beats + DONE 1 cycle, so refill_done arrives 10 cycles after accept.
- Latency, dirty miss: adds WB_RD 2 cycles + AW 1 + W 8 + B ≥1 ahead of the refill.
- Reset asserted mid-burst returns immediately to IDLE with all outputs at reset values. The bus side is assumed reset by the same rst.

Test Plan:
- Clean miss, miss_addr=32'h0000_1234, zero-wait slave returning 8 words 32'hA0..A7 -> araddr=32'h0000_1220, arlen=7. Bank n written with A0+n at ram_addr[11:5]=7'h11. refill_done 10 cycles after accept.
- Dirty miss, victim_tag=20'h12345, idx 7'h11, ram_rdata words 32'hD0..D7 -> awaddr=32'h1234_5220. wdata D0..D7 in order, wlast on the 8th beat only. AR issued only after bvalid.
- Backpressure: wready toggling 1,0,1,0…, rvalid with random gaps -> no beat lost or duplicated. Valid/data held stable while stalled. Bank order 0..7 is preserved.
- Early rlast on beat 4 -> banks 0-3 written, banks 4-7 untouched, refill_done pulses the following cycle.
- rst asserted during RF_R beat 3 -> same-cycle return to reset outputs. Next miss_req is processed normally from counter 0.
- miss_req held high through busy -> exactly one refill per IDLE visit. A second miss is accepted the cycle after DONE.
